// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
// Contents: FSM state encoding, response-field constants, wait-counter width
// and a constant function that derives the word-index width from the depth.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Response error flag values
  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Wait-state counter width (supports WAIT up to 15)
  localparam int CNT_W = 4;

  // Number of index bits needed to address 'depth' words (ceil(log2(depth)))
  function automatic int idx_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(depth)) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Synchronous single-port word store, no reset (contents survive reset).
// Ports:
//   clk   - rising-edge clock
//   en    - read enable: registers mem[idx] into rdata
//   we    - write enable: writes wdata into mem[idx]
//   idx   - word index
//   wdata - write data
//   rdata - registered read data (value before any same-edge write)
module data_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
    if (en) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data load/store path. Accepts one
// request at a time, waits WAIT cycles, then presents a load result or a
// store acknowledge until the core takes it.
// Ports:
//   clk, reset      - clock; asynchronous active-low reset
//   req_valid/ready - request handshake (ready only in IDLE)
//   req_we          - 1 = store, 0 = load
//   req_addr        - byte address, bits [1:0] ignored
//   req_wdata       - store data
//   resp_valid/ready- response handshake
//   resp_rdata      - load data, 0 for stores and errors
//   resp_err        - address out of range
//   busy            - transaction in progress
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic NO_WAIT = (WAIT == 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : {CNT_W{1'b0}};

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              enter_resp_s;
  logic              accept_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic              req_range_s;

  logic              we_r, range_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] wdata_r;

  logic              cur_we_s, cur_range_s;
  logic [IDX_W-1:0]  cur_idx_s;
  logic [DATA_W-1:0] cur_wdata_s;

  logic              resp_valid_r, resp_err_r, resp_load_r;
  logic              arr_we_s;
  logic [DATA_W-1:0] arr_rdata_s;
  logic              unused_addr_s;

  assign req_ready   = (state_r == ST_IDLE);
  assign busy        = (state_r != ST_IDLE);
  assign accept_s    = req_valid & req_ready;
  assign req_idx_s   = req_addr[IDX_W+1:2];
  assign req_range_s = ((req_addr >> (IDX_W + 2)) == {ADDR_W{1'b0}});
  assign unused_addr_s = ^req_addr[1:0];

  // With zero wait states RESP is entered on the accept edge itself, so the
  // array and response registers must see the live request, not the latch.
  assign cur_we_s    = (state_r == ST_IDLE) ? req_we      : we_r;
  assign cur_range_s = (state_r == ST_IDLE) ? req_range_s : range_r;
  assign cur_idx_s   = (state_r == ST_IDLE) ? req_idx_s   : idx_r;
  assign cur_wdata_s = (state_r == ST_IDLE) ? req_wdata   : wdata_r;

  // Writes are also blocked while reset is held so no store can slip in.
  assign arr_we_s = enter_resp_s & cur_we_s & cur_range_s & reset;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && NO_WAIT) begin
          state_nxt_s  = ST_RESP;
          enter_resp_s = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s  = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Request latch, captured on the accept edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r    <= 1'b0;
      range_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      we_r    <= req_we;
      range_r <= req_range_s;
      idx_r   <= req_idx_s;
      wdata_r <= req_wdata;
    end
  end

  // Response registers: set entering RESP, cleared on the response handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= RESP_OK;
      resp_load_r  <= 1'b0;
    end else if (enter_resp_s) begin
      resp_valid_r <= 1'b1;
      resp_err_r   <= cur_range_s ? RESP_OK : RESP_ERR;
      resp_load_r  <= ~cur_we_s & cur_range_s;
    end else if (resp_valid_r && resp_ready) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= RESP_OK;
      resp_load_r  <= 1'b0;
    end
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp_s),
    .we    (arr_we_s),
    .idx   (cur_idx_s),
    .wdata (cur_wdata_s),
    .rdata (arr_rdata_s)
  );

  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_load_r ? arr_rdata_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: one responder built with WAIT=2, one with WAIT=0.
// Expected responses are predicted from a word-level memory model when a
// request is accepted and compared when the response is presented.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [int];
  logic [32:0] q_a [$];
  logic [32:0] q_b [$];

  data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT(2)) dut_w2 (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
  );

  data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT(0)) dut_w0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the DEPTH=256 store: returns {err, rdata} and applies stores
  function automatic logic [32:0] predict(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata);
    logic err;
    int   idx;
    err = (addr[31:10] != 22'd0);
    idx = int'(addr[9:2]);
    if (err) return {1'b1, 32'h0};
    if (we) begin
      model[idx] = wdata;
      return {1'b0, 32'h0};
    end
    if (model.exists(idx)) return {1'b0, model[idx]};
    return {1'b0, 32'h0};
  endfunction

  // One request to the WAIT=2 responder; hold = cycles of resp_ready low
  task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, input string tag);
    logic [32:0] e;
    int lat;
    a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_valid = 1'b1;
    a_resp_ready = (hold == 0);
    check_eq({tag, "_req_ready"}, a_req_ready, 32'd1);
    step();
    a_req_valid = 1'b0;
    a_req_addr = 32'hFFFF_FFFC;
    a_req_wdata = 32'h0BAD_0BAD;
    q_a.push_back(predict(we, addr, wdata));
    check_eq({tag, "_ready_drop"}, a_req_ready, 32'd0);
    lat = 1;
    while (!a_resp_valid && lat < 40) begin
      step();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 32'd3);
    e = q_a.pop_front();
    for (int i = 0; i < hold; i++) begin
      check_eq({tag, "_hold_valid"}, a_resp_valid, 32'd1);
      check_eq({tag, "_hold_rdata"}, a_resp_rdata, e[31:0]);
      check_eq({tag, "_hold_err"}, a_resp_err, {31'd0, e[32]});
      check_eq({tag, "_hold_ready"}, a_req_ready, 32'd0);
      step();
    end
    a_resp_ready = 1'b1;
    check_eq({tag, "_rdata"}, a_resp_rdata, e[31:0]);
    check_eq({tag, "_err"}, a_resp_err, {31'd0, e[32]});
    step();
    check_eq({tag, "_valid_drop"}, a_resp_valid, 32'd0);
    check_eq({tag, "_idle"}, a_busy, 32'd0);
  endtask

  initial begin
    int seen;
    int acc;
    int last;
    logic [32:0] e;

    reset = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;

    check_eq("rst_a_req_ready", a_req_ready, 32'd1);
    check_eq("rst_a_resp_valid", a_resp_valid, 32'd0);
    check_eq("rst_a_busy", a_busy, 32'd0);
    check_eq("rst_a_rdata", a_resp_rdata, 32'd0);
    check_eq("rst_a_err", a_resp_err, 32'd0);
    check_eq("rst_b_req_ready", b_req_ready, 32'd1);
    check_eq("rst_b_resp_valid", b_resp_valid, 32'd0);
    check_eq("rst_b_busy", b_busy, 32'd0);
    step();

    req_a(1'b1, 32'h10,  32'hDEAD_BEEF, 0, "st10");
    req_a(1'b0, 32'h10,  32'h0,         0, "ld10");
    req_a(1'b1, 32'h0,   32'hCAFE_0001, 0, "st0");
    req_a(1'b0, 32'h10,  32'h0,         5, "bp_ld10");
    req_a(1'b1, 32'h400, 32'h1,         0, "st400");
    req_a(1'b0, 32'h0,   32'h0,         0, "ld0");
    req_a(1'b0, 32'h400, 32'h0,         0, "ld400");
    req_a(1'b1, 32'h20,  32'h11,        0, "st20");

    // Reset during WAIT aborts an uncommitted store
    a_req_we = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h55; a_req_valid = 1'b1;
    step();
    a_req_valid = 1'b0;
    check_eq("abort_busy_before", a_busy, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("abort_busy_async", a_busy, 32'd0);
    check_eq("abort_ready_async", a_req_ready, 32'd1);
    step();
    step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_resp_valid) seen++;
    end
    check_eq("abort_no_resp", seen, 32'd0);
    req_a(1'b0, 32'h20, 32'h0, 0, "ld20_after_abort");

    // WAIT=0: single store, response on the cycle after accept
    b_req_we = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hA5A5_A5A5; b_req_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
    q_b.push_back({1'b0, 32'h0});
    check_eq("w0_st_valid", b_resp_valid, 32'd1);
    e = q_b.pop_front();
    check_eq("w0_st_rdata", b_resp_rdata, e[31:0]);
    check_eq("w0_st_err", b_resp_err, {31'd0, e[32]});
    step();
    check_eq("w0_st_valid_drop", b_resp_valid, 32'd0);

    // WAIT=0: back-to-back loads with req_valid held high
    b_req_we = 1'b0; b_req_addr = 32'h8; b_req_valid = 1'b1;
    acc = 0;
    last = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (b_req_ready) begin
        acc++;
        if (acc > 1) check_eq("w0_accept_spacing", cyc - last, 32'd2);
        last = cyc;
        q_b.push_back({1'b0, 32'hA5A5_A5A5});
      end
      if (b_resp_valid) begin
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          check_eq("w0_ld_rdata", b_resp_rdata, e[31:0]);
          check_eq("w0_ld_err", b_resp_err, {31'd0, e[32]});
        end else begin
          check_eq("w0_unexpected_resp", b_resp_valid, 32'd0);
        end
      end
      if (cyc == 7) b_req_valid = 1'b0;
      step();
    end
    if (b_resp_valid && q_b.size() > 0) begin
      e = q_b.pop_front();
      check_eq("w0_ld_rdata_last", b_resp_rdata, e[31:0]);
    end
    check_eq("w0_accept_count", acc, 32'd4);
    check_eq("w0_queue_empty", q_b.size(), 32'd0);
    check_eq("a_queue_empty", q_a.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
